// File: rtl/fmcw_pkg.sv
// Shared definitions for the FMCW capture path: default FFT size and the
// writer/reader state encodings used by fft_frame_ctrl.
package fmcw_pkg;

  localparam int unsigned FFT_N = 1024;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ARM  = 2'd1;
  localparam logic [1:0] W_FILL = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_RUN   = 2'd1;
  localparam logic [1:0] R_FLUSH = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Ping-pong frame sequencer: writer fills one RAM bank from the FIR while the
// reader streams the other bank into the FFT and waits for its output to drain.
module fft_frame_ctrl
  import fmcw_pkg::*;
#(
  parameter int unsigned N         = FFT_N,
  parameter int unsigned ADDR_W    = $clog2(N),
  parameter int unsigned FRAME_W   = 16,
  parameter int unsigned FLUSH_LEN = N + 8
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              sample_en_i,
  input  logic              fir_dvalid_i,
  input  logic              ramp_start_i,
  input  logic              rd_step_en_i,
  output logic              wr_en_o,
  output logic [ADDR_W:0]   wr_addr_o,
  output logic              rd_en_o,
  output logic [ADDR_W:0]   rd_addr_o,
  output logic              fft_rst_n_o,
  output logic              frame_done_o,
  output logic [FRAME_W-1:0] frame_ctr_o,
  output logic [FRAME_W-1:0] drop_ctr_o,
  output logic              overrun_o
);

  localparam int unsigned         FC_W       = $clog2(FLUSH_LEN + 1);
  localparam logic [ADDR_W-1:0]   IDX_LAST   = ADDR_W'(N - 1);
  localparam logic [FC_W-1:0]     FLUSH_LAST = FC_W'(FLUSH_LEN - 1);

  logic [1:0]        w_state;
  logic [1:0]        r_state;
  logic              wbank;
  logic              rbank;
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] ridx;
  logic [FC_W-1:0]   flush_cnt;

  logic wr_fire;
  logic fill_done;
  logic reader_done;
  logic reader_free;
  logic handoff;
  logic drop;

  assign wr_fire     = (w_state == W_FILL) && sample_en_i && fir_dvalid_i;
  assign fill_done   = wr_fire && (widx == IDX_LAST);
  assign reader_done = (r_state == R_FLUSH) && (flush_cnt == FLUSH_LAST);
  // A reader finishing its flush this very cycle is free to take the new bank.
  assign reader_free = (r_state == R_IDLE) || reader_done;
  assign handoff     = fill_done && reader_free;
  assign drop        = fill_done && !reader_free;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      wbank     <= 1'b0;
      widx      <= '0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      overrun_o <= 1'b0;
    end else begin
      wr_en_o <= wr_fire;
      if (wr_fire) begin
        wr_addr_o <= {wbank, widx};
        widx      <= widx + ADDR_W'(1);
      end
      if (drop) begin
        overrun_o <= 1'b1;
      end
      case (w_state)
        W_IDLE: begin
          if (enable_i) w_state <= W_ARM;
        end
        W_ARM: begin
          if (!enable_i) begin
            w_state <= W_IDLE;
          end else if (ramp_start_i) begin
            w_state <= W_FILL;
            widx    <= '0;
          end
        end
        W_FILL: begin
          if (fill_done) begin
            w_state <= enable_i ? W_ARM : W_IDLE;
            if (handoff) wbank <= ~wbank;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state      <= R_IDLE;
      rbank        <= 1'b0;
      ridx         <= '0;
      flush_cnt    <= '0;
      rd_en_o      <= 1'b0;
      rd_addr_o    <= '0;
      fft_rst_n_o  <= 1'b0;
      frame_done_o <= 1'b0;
      frame_ctr_o  <= '0;
    end else begin
      rd_en_o      <= 1'b0;
      frame_done_o <= 1'b0;
      // Follows the state one cycle late, so a back-to-back handoff still
      // gives the FFT a single low reset cycle between frames.
      fft_rst_n_o  <= (r_state != R_IDLE) && !reader_done;
      case (r_state)
        R_RUN: begin
          if (rd_step_en_i) begin
            rd_en_o   <= 1'b1;
            rd_addr_o <= {rbank, ridx};
            ridx      <= ridx + ADDR_W'(1);
            if (ridx == IDX_LAST) begin
              r_state   <= R_FLUSH;
              flush_cnt <= '0;
            end
          end
        end
        R_FLUSH: begin
          if (reader_done) begin
            frame_done_o <= 1'b1;
            frame_ctr_o  <= frame_ctr_o + FRAME_W'(1);
            r_state      <= R_IDLE;
          end else begin
            flush_cnt <= flush_cnt + FC_W'(1);
          end
        end
        default: ;
      endcase
      if (handoff) begin
        r_state <= R_RUN;
        rbank   <= wbank;
        ridx    <= '0;
      end
    end
  end

  sat_counter #(
    .WIDTH(FRAME_W)
  ) u_drop_ctr (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .inc_i  (drop),
    .count_o(drop_ctr_o)
  );

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl (N=16, FLUSH_LEN=24) against a
// frame-level model of bank ownership, drops and expected address streams.
module tb_fft_frame_ctrl;

  localparam int unsigned N       = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned FW      = 16;
  localparam int unsigned FL      = 24;
  localparam int unsigned SPACING = 20;

  logic          clk_i        = 1'b0;
  logic          rst_n        = 1'b0;
  logic          enable_i     = 1'b0;
  logic          sample_en_i  = 1'b0;
  logic          fir_dvalid_i = 1'b0;
  logic          ramp_start_i = 1'b0;
  logic          rd_step_en_i = 1'b0;
  logic          wr_en_o;
  logic [AW:0]   wr_addr_o;
  logic          rd_en_o;
  logic [AW:0]   rd_addr_o;
  logic          fft_rst_n_o;
  logic          frame_done_o;
  logic [FW-1:0] frame_ctr_o;
  logic [FW-1:0] drop_ctr_o;
  logic          overrun_o;

  fft_frame_ctrl #(
    .N(N), .ADDR_W(AW), .FRAME_W(FW), .FLUSH_LEN(FL)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n), .enable_i(enable_i), .sample_en_i(sample_en_i),
    .fir_dvalid_i(fir_dvalid_i), .ramp_start_i(ramp_start_i), .rd_step_en_i(rd_step_en_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .fft_rst_n_o(fft_rst_n_o), .frame_done_o(frame_done_o), .frame_ctr_o(frame_ctr_o),
    .drop_ctr_o(drop_ctr_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc      = 0;
  int          rd_mode  = 0;  // 0: hold, 1: step every cycle, 2: random
  int          wq[$];
  int          rq[$];
  int unsigned done_q[$];
  int unsigned low_q[$];
  int unsigned last_rd_cyc = 0;
  int unsigned lowrun      = 0;

  // Reference model state (frame level)
  int m_wbank  = 0;
  int m_drops  = 0;
  int m_frames = 0;
  int exp_rq[$];

  always @(negedge clk_i) begin
    cyc++;
    rd_step_en_i = (rd_mode == 1) || (rd_mode == 2 && $urandom_range(1) == 1);
    if (wr_en_o === 1'b1) wq.push_back(int'(wr_addr_o));
    if (rd_en_o === 1'b1) begin
      rq.push_back(int'(rd_addr_o));
      last_rd_cyc = cyc;
    end
    if (frame_done_o === 1'b1) done_q.push_back(cyc);
    if (fft_rst_n_o === 1'b0) lowrun++;
    else if (lowrun != 0) begin
      low_q.push_back(lowrun);
      lowrun = 0;
    end
  end

  function automatic int frame_addr(input int bank, input int idx);
    return bank * N + idx;
  endfunction

  // A completed fill either goes to an idle reader or is dropped.
  function automatic void model_fill_done(input bit reader_idle);
    if (reader_idle) begin
      for (int i = 0; i < N; i++) exp_rq.push_back(frame_addr(m_wbank, i));
      m_wbank = 1 - m_wbank;
      m_frames++;
    end else if (m_drops < 65535) begin
      m_drops++;
    end
  endfunction

  function automatic void bank_addrs(input int bank, output int q[$]);
    q = {};
    for (int i = 0; i < N; i++) q.push_back(frame_addr(bank, i));
  endfunction

  function automatic int first_diff(input int a[$], input int b[$]);
    if (a.size() != b.size()) return -2;
    foreach (a[i]) if (a[i] != b[i]) return i;
    return -1;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({wr_en_o, wr_addr_o, rd_en_o, rd_addr_o, fft_rst_n_o, frame_done_o,
                frame_ctr_o, drop_ctr_o, overrun_o});
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      sample_en_i  = 1'b0;
      ramp_start_i = 1'b0;
      fir_dvalid_i = 1'($urandom);
    end
  endtask

  task automatic pulse_ramp();
    tick();
    sample_en_i  = 1'b0;
    ramp_start_i = 1'b1;
    idle(1);
  endtask

  task automatic send_sample(input bit v);
    idle(SPACING - 1);
    tick();
    sample_en_i  = 1'b1;
    fir_dvalid_i = v;
    ramp_start_i = 1'b0;
  endtask

  task automatic fill_frame(input bit gaps, output int gapw);
    int valid = 0;
    int slot  = 0;
    bit v;
    gapw = -1;
    pulse_ramp();
    while (valid < N) begin
      v = 1'b1;
      if (gaps) begin
        if (slot == 6) gapw = wq.size();
        if (slot >= 3 && slot <= 5) v = 1'b0;
        else if (slot > 5) v = ($urandom_range(3) != 0);
        if (slot == 8) pulse_ramp();
      end
      send_sample(v);
      if (v) valid++;
      slot++;
    end
    idle(3);
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      idle(1);
      if (done_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    rd_mode = 2;
    for (int i = 0; i < 4; i++) begin
      tick();
      enable_i     = 1'($urandom);
      sample_en_i  = 1'($urandom);
      fir_dvalid_i = 1'($urandom);
      ramp_start_i = 1'($urandom);
      @(negedge clk_i);
      n_checks++;
      if (outs() !== 64'd0) $display("FAIL reset_outs[%0d]: got %h expected 0", i, outs());
      else n_pass++;
    end
    n_checks++;
    if (wq.size() !== 0) $display("FAIL reset_no_write: got %0d writes expected 0", wq.size());
    else n_pass++;
    tick();
    rst_n = 1'b1; enable_i = 1'b0; sample_en_i = 1'b0; ramp_start_i = 1'b0;
    rd_mode = 0;
    idle(2);
  endtask

  task automatic test_single_frame();
    int  exp_w[$];
    int  d;
    int  gw;
    bit  ok;
    int unsigned lat;
    wq.delete(); rq.delete(); done_q.delete(); exp_rq.delete();
    enable_i = 1'b1;
    idle(3);
    fill_frame(1'b0, gw);
    bank_addrs(m_wbank, exp_w);
    model_fill_done(1'b1);
    d = first_diff(wq, exp_w);
    n_checks++;
    if (d !== -1) $display("FAIL wr_addrs_f1: diff %0d got %0d writes expected %0d", d, wq.size(), exp_w.size());
    else n_pass++;
    n_checks++;
    if (rq.size() !== 0) $display("FAIL rd_hold: got %0d reads expected 0", rq.size());
    else n_pass++;
    n_checks++;
    if (fft_rst_n_o !== 1'b1) $display("FAIL fft_rst_run: got %b expected 1", fft_rst_n_o);
    else n_pass++;

    rd_mode = 1;
    wait_done(1, 200, ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL done_f1: got timeout expected frame_done");
    else n_pass++;
    d = first_diff(rq, exp_rq);
    n_checks++;
    if (d !== -1) $display("FAIL rd_addrs_f1: diff %0d got %0d reads expected %0d", d, rq.size(), exp_rq.size());
    else n_pass++;
    lat = (done_q.size() > 0) ? done_q[0] - last_rd_cyc : 0;
    n_checks++;
    if (lat !== FL) $display("FAIL flush_len: got %0d expected %0d", lat, FL);
    else n_pass++;
    idle(2);
    n_checks++;
    if (frame_ctr_o !== FW'(m_frames)) $display("FAIL frame_ctr_f1: got %0d expected %0d", frame_ctr_o, m_frames);
    else n_pass++;
    n_checks++;
    if (done_q.size() !== 1) $display("FAIL done_pulse: got %0d pulses expected 1", done_q.size());
    else n_pass++;

    wq.delete(); rq.delete(); done_q.delete(); exp_rq.delete();
    fill_frame(1'b0, gw);
    bank_addrs(m_wbank, exp_w);
    model_fill_done(1'b1);
    d = first_diff(wq, exp_w);
    n_checks++;
    if (d !== -1) $display("FAIL wr_addrs_f2: diff %0d got %0d writes expected %0d", d, wq.size(), exp_w.size());
    else n_pass++;
    wait_done(1, 200, ok);
    idle(2);
    n_checks++;
    if (frame_ctr_o !== FW'(m_frames)) $display("FAIL frame_ctr_f2: got %0d expected %0d", frame_ctr_o, m_frames);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int exp_w[$];
    int d;
    int gw;
    bit ok;
    rd_mode = 0;
    wq.delete(); rq.delete(); done_q.delete(); exp_rq.delete();
    for (int f = 0; f < 3; f++) begin
      wq.delete();
      fill_frame(1'b0, gw);
      bank_addrs(m_wbank, exp_w);
      model_fill_done(f == 0);
      d = first_diff(wq, exp_w);
      n_checks++;
      if (d !== -1) $display("FAIL wr_addrs_ovr[%0d]: diff %0d got %0d writes", f, d, wq.size());
      else n_pass++;
      n_checks++;
      if (drop_ctr_o !== FW'(m_drops)) $display("FAIL drop_ctr[%0d]: got %0d expected %0d", f, drop_ctr_o, m_drops);
      else n_pass++;
      n_checks++;
      if (overrun_o !== (m_drops != 0)) $display("FAIL overrun[%0d]: got %b expected %b", f, overrun_o, m_drops != 0);
      else n_pass++;
    end
    rd_mode = 1;
    wait_done(1, 200, ok);
    idle(2);
    d = first_diff(rq, exp_rq);
    n_checks++;
    if (d !== -1 || ok !== 1'b1) $display("FAIL rd_addrs_ovr: diff %0d got %0d reads expected %0d", d, rq.size(), exp_rq.size());
    else n_pass++;
    n_checks++;
    if (frame_ctr_o !== FW'(m_frames)) $display("FAIL frame_ctr_ovr: got %0d expected %0d", frame_ctr_o, m_frames);
    else n_pass++;
  endtask

  task automatic test_gaps();
    int exp_w[$];
    int d;
    int gw;
    bit ok;
    rd_mode = 1;
    wq.delete(); rq.delete(); done_q.delete(); exp_rq.delete();
    fill_frame(1'b1, gw);
    bank_addrs(m_wbank, exp_w);
    model_fill_done(1'b1);
    n_checks++;
    if (gw !== 3) $display("FAIL gap_writes: got %0d writes before gap end expected 3", gw);
    else n_pass++;
    d = first_diff(wq, exp_w);
    n_checks++;
    if (d !== -1) $display("FAIL wr_addrs_gap: diff %0d got %0d writes expected %0d", d, wq.size(), exp_w.size());
    else n_pass++;
    wait_done(1, 200, ok);
    idle(2);
    d = first_diff(rq, exp_rq);
    n_checks++;
    if (d !== -1 || ok !== 1'b1) $display("FAIL rd_addrs_gap: diff %0d got %0d reads expected %0d", d, rq.size(), exp_rq.size());
    else n_pass++;
    n_checks++;
    if (frame_ctr_o !== FW'(m_frames)) $display("FAIL frame_ctr_gap: got %0d expected %0d", frame_ctr_o, m_frames);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int exp_w[$];
    int d;
    int gw;
    int unsigned gap;
    bit ok;
    rd_mode = 0;
    wq.delete(); rq.delete(); done_q.delete(); exp_rq.delete();
    fill_frame(1'b0, gw);
    model_fill_done(1'b1);
    low_q.delete();
    wq.delete();
    pulse_ramp();
    for (int i = 0; i < N - 1; i++) send_sample(1'b1);
    idle(5);
    // Reader: N steps then FL flush cycles; last sample lands on flush completion.
    tick();
    rd_mode = 1;
    sample_en_i = 1'b0;
    idle(N + FL - 2);
    tick();
    sample_en_i  = 1'b1;
    fir_dvalid_i = 1'b1;
    bank_addrs(m_wbank, exp_w);
    model_fill_done(1'b1);
    idle(3);
    wait_done(2, 200, ok);
    idle(2);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL done_b2b: got timeout expected two frame_done pulses");
    else n_pass++;
    d = first_diff(wq, exp_w);
    n_checks++;
    if (d !== -1) $display("FAIL wr_addrs_b2b: diff %0d got %0d writes expected %0d", d, wq.size(), exp_w.size());
    else n_pass++;
    d = first_diff(rq, exp_rq);
    n_checks++;
    if (d !== -1) $display("FAIL rd_addrs_b2b: diff %0d got %0d reads expected %0d", d, rq.size(), exp_rq.size());
    else n_pass++;
    n_checks++;
    if (drop_ctr_o !== FW'(m_drops)) $display("FAIL drop_b2b: got %0d expected %0d", drop_ctr_o, m_drops);
    else n_pass++;
    gap = (low_q.size() == 1) ? low_q[0] : 999;
    n_checks++;
    if (gap !== 1) $display("FAIL rst_gap: got %0d low cycles (%0d runs) expected 1", gap, low_q.size());
    else n_pass++;
    n_checks++;
    if (frame_ctr_o !== FW'(m_frames)) $display("FAIL frame_ctr_b2b: got %0d expected %0d", frame_ctr_o, m_frames);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int exp_w[$];
    int d;
    int gw;
    rd_mode = 0;
    pulse_ramp();
    for (int i = 0; i < 5; i++) send_sample(1'b1);
    idle(2);
    rst_n = 1'b0;
    idle(2);
    n_checks++;
    if (outs() !== 64'd0) $display("FAIL rst_mid_fill: got %h expected 0", outs());
    else n_pass++;
    rst_n = 1'b1;
    m_wbank = 0; m_drops = 0; m_frames = 0;
    exp_rq.delete(); wq.delete(); rq.delete();
    for (int i = 0; i < N; i++) send_sample(1'b1);
    idle(3);
    n_checks++;
    if (wq.size() !== 0) $display("FAIL no_ramp_fill: got %0d writes expected 0", wq.size());
    else n_pass++;
    fill_frame(1'b0, gw);
    bank_addrs(m_wbank, exp_w);
    model_fill_done(1'b1);
    d = first_diff(wq, exp_w);
    n_checks++;
    if (d !== -1) $display("FAIL wr_addrs_rst: diff %0d got %0d writes expected %0d", d, wq.size(), exp_w.size());
    else n_pass++;
    rd_mode = 1;
    idle(5);
    rd_mode = 0;
    rst_n = 1'b0;
    idle(2);
    n_checks++;
    if (outs() !== 64'd0) $display("FAIL rst_mid_run: got %h expected 0", outs());
    else n_pass++;
    rst_n = 1'b1;
    wq.delete(); rq.delete();
    rd_mode = 1;
    for (int i = 0; i < N; i++) send_sample(1'b1);
    idle(3);
    n_checks++;
    if (wq.size() !== 0 || rq.size() !== 0)
      $display("FAIL after_rst_idle: got %0d writes %0d reads expected 0 and 0", wq.size(), rq.size());
    else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_overrun();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
